// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with a one-cycle sign fix-up.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iStart,
   input  logic [2:0]       iOp,
   input  logic             iFlush,
   input  logic [WIDTH-1:0] iOperandA,
   input  logic [WIDTH-1:0] iOperandB,
   output logic             oBusy,
   output logic             oDone,
   output logic             oDivByZero,
   output logic [WIDTH-1:0] oHI,
   output logic [WIDTH-1:0] oLO
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      cond_neg = neg ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      cond_neg2 = neg ? ({(2*WIDTH){1'b0}} - v) : v;
   endfunction

   logic [1:0]         state_r;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [WIDTH-1:0]   opnd_r;
   logic [WIDTH-1:0]   quot_r;
   logic [WIDTH-1:0]   rem_r;
   logic               is_div_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic               dbz_r;

   logic               accept_s;
   logic               signed_op_s;
   logic               sa_s;
   logic               sb_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic               last_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] prod_next_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic [WIDTH-1:0]   rem_next_s;
   logic [WIDTH-1:0]   quot_next_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quot_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   assign oBusy = (state_r != ST_IDLE);

   // Operand decode at accept: only signed ops take magnitudes and carry sign flags.
   always_comb begin
      accept_s    = (state_r == ST_IDLE) && iStart && !iFlush;
      signed_op_s = (iOp == OP_MULT) || (iOp == OP_DIV);
      sa_s        = signed_op_s & iOperandA[WIDTH-1];
      sb_s        = signed_op_s & iOperandB[WIDTH-1];
      mag_a_s     = cond_neg(iOperandA, sa_s);
      mag_b_s     = cond_neg(iOperandB, sb_s);
      last_s      = (cnt_r == CW'(WIDTH-1));
   end

   // Multiply step: multiplier sits in the low half and is shifted out as the sum shifts in.
   always_comb begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
      if (prod_r[0]) begin
         mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
      end else begin
         mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
      end
      prod_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
   end

   // Restoring divide step; the trial difference fits WIDTH bits whenever it is kept.
   always_comb begin
      div_shift_s = {rem_r, quot_r[WIDTH-1]};
      div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
      if (div_shift_s >= {1'b0, opnd_r}) begin
         rem_next_s  = div_diff_s;
         quot_next_s = {quot_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_next_s  = div_shift_s[WIDTH-1:0];
         quot_next_s = {quot_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up; a zero divisor leaves the remainder equal to A and forces an all-ones quotient.
   always_comb begin
      prod_fix_s = cond_neg2(prod_r, neg_q_r);
      rem_fix_s  = cond_neg(rem_r, neg_r_r);
      if (dbz_r) begin
         quot_fix_s = {WIDTH{1'b1}};
      end else begin
         quot_fix_s = cond_neg(quot_r, neg_q_r);
      end
   end

   // Sequencer, datapath registers and HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         prod_r     <= {(2*WIDTH){1'b0}};
         opnd_r     <= {WIDTH{1'b0}};
         quot_r     <= {WIDTH{1'b0}};
         rem_r      <= {WIDTH{1'b0}};
         is_div_r   <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         dbz_r      <= 1'b0;
         oDone      <= 1'b0;
         oDivByZero <= 1'b0;
         oHI        <= {WIDTH{1'b0}};
         oLO        <= {WIDTH{1'b0}};
      end else begin
         oDone      <= 1'b0;
         oDivByZero <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  case (iOp)
                     OP_MULT, OP_MULTU: begin
                        prod_r   <= {{WIDTH{1'b0}}, mag_b_s};
                        opnd_r   <= mag_a_s;
                        neg_q_r  <= sa_s ^ sb_s;
                        neg_r_r  <= sa_s;
                        is_div_r <= 1'b0;
                        dbz_r    <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= ST_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        quot_r   <= mag_a_s;
                        rem_r    <= {WIDTH{1'b0}};
                        opnd_r   <= mag_b_s;
                        neg_q_r  <= sa_s ^ sb_s;
                        neg_r_r  <= sa_s;
                        is_div_r <= 1'b1;
                        dbz_r    <= (iOperandB == {WIDTH{1'b0}});
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= ST_DIV;
                     end
                     OP_MTHI: oHI <= iOperandA;
                     OP_MTLO: oLO <= iOperandA;
                     default: state_r <= ST_IDLE;
                  endcase
               end
            end
            ST_MUL: begin
               prod_r <= prod_next_s;
               cnt_r  <= cnt_r + CW'(1);
               if (last_s) begin
                  state_r <= ST_FIX;
               end
            end
            ST_DIV: begin
               rem_r  <= rem_next_s;
               quot_r <= quot_next_s;
               cnt_r  <= cnt_r + CW'(1);
               if (last_s) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (is_div_r) begin
                  oLO        <= quot_fix_s;
                  oHI        <= rem_fix_s;
                  oDivByZero <= dbz_r;
               end else begin
                  {oHI, oLO} <= prod_fix_s;
               end
               oDone   <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam int W = 32;
   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic          clk = 1'b0;
   logic          reset;
   logic          iStart;
   logic [2:0]    iOp;
   logic          iFlush;
   logic [W-1:0]  iOperandA;
   logic [W-1:0]  iOperandB;
   logic          oBusy;
   logic          oDone;
   logic          oDivByZero;
   logic [W-1:0]  oHI;
   logic [W-1:0]  oLO;

   int            vectors = 0;
   int            errors  = 0;
   logic [31:0]   exp_hi, exp_lo;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_dz;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .iStart(iStart), .iOp(iOp), .iFlush(iFlush),
      .iOperandA(iOperandA), .iOperandB(iOperandB), .oBusy(oBusy), .oDone(oDone),
      .oDivByZero(oDivByZero), .oHI(oHI), .oLO(oLO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS-style results straight from integer arithmetic.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      dz = 1'b0;
      hi = 32'h0;
      lo = 32'h0;
      case (op)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            hi = sp[63:32];
            lo = sp[31:0];
         end
         OP_MULTU: begin
            up = {32'h0, a} * {32'h0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b == 32'h0) begin
               dz = 1'b1;
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (op == OP_DIVU) begin
               lo = a / b;
               hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'h0;
            end else begin
               sa = $signed(a);
               sb = $signed(b);
               lo = 32'(sa / sb);
               hi = 32'(sa % sb);
            end
         end
         default: dz = 1'b0;
      endcase
   endtask

   // Called at a negedge; returns 1 ns after the accepting edge.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      model(op, a, b, pend_hi, pend_lo, pend_dz);
      iStart = 1'b1; iOp = op; iOperandA = a; iOperandB = b; iFlush = 1'b0;
      @(posedge clk);
      #1;
      iStart = 1'b0; iOp = OP_NONE; iOperandA = $urandom; iOperandB = $urandom;
   endtask

   // Counts remaining busy cycles, then checks the completion cycle; ends at a negedge.
   task automatic finish_op(input string tag, input int exp_busy);
      int n = 0;
      int early = 0;
      @(negedge clk);
      while (oBusy && n < 100) begin
         n++;
         if (oDone) early++;
         @(negedge clk);
      end
      check({tag, "/busy_cycles"}, n, exp_busy);
      check({tag, "/done_while_busy"}, early, 0);
      check({tag, "/done"}, {31'h0, oDone}, 32'h1);
      check({tag, "/dbz"}, {31'h0, oDivByZero}, {31'h0, pend_dz});
      check({tag, "/hi"}, oHI, pend_hi);
      check({tag, "/lo"}, oLO, pend_lo);
      exp_hi = pend_hi;
      exp_lo = pend_lo;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start_op(op, a, b);
      finish_op(tag, W + 1);
   endtask

   task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
      iStart = 1'b1; iOp = op; iOperandA = a; iFlush = 1'b0;
      @(posedge clk);
      #1;
      iStart = 1'b0; iOp = OP_NONE;
      @(negedge clk);
      if (op == OP_MTHI) exp_hi = a; else exp_lo = a;
      check({tag, "/hi"}, oHI, exp_hi);
      check({tag, "/lo"}, oLO, exp_lo);
      check({tag, "/busy"}, {31'h0, oBusy}, 32'h0);
      check({tag, "/done"}, {31'h0, oDone}, 32'h0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          dn;

      reset = 1'b1; iStart = 1'b0; iOp = OP_NONE; iFlush = 1'b0;
      iOperandA = 32'h0; iOperandB = 32'h0;
      exp_hi = 32'h0; exp_lo = 32'h0;
      repeat (2) @(negedge clk);
      check("reset/busy", {31'h0, oBusy}, 32'h0);
      check("reset/done", {31'h0, oDone}, 32'h0);
      check("reset/dbz", {31'h0, oDivByZero}, 32'h0);
      check("reset/hi", oHI, 32'h0);
      check("reset/lo", oLO, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Directed corner cases, issued back to back in the first idle cycle.
      run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'h5);
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0);
      run_op("div_neg_zero", OP_DIV, 32'hFFFF_FFFB, 32'h0);
      run_op("mult_minneg", OP_MULT, 32'h8000_0000, 32'h8000_0000);
      @(negedge clk);
      check("done_one_cycle", {31'h0, oDone}, 32'h0);

      // Flushed start must be dropped.
      iStart = 1'b1; iOp = OP_MULT; iFlush = 1'b1; iOperandA = 32'h7; iOperandB = 32'h9;
      @(posedge clk);
      #1;
      iStart = 1'b0; iFlush = 1'b0; iOp = OP_NONE;
      @(negedge clk);
      check("flush/busy", {31'h0, oBusy}, 32'h0);
      check("flush/hi", oHI, exp_hi);
      check("flush/lo", oLO, exp_lo);

      // mthi while busy is ignored; the multiply result lands in HI.
      start_op(OP_MULT, 32'h0000_1357, 32'hFFFF_0003);
      repeat (3) @(negedge clk);
      iStart = 1'b1; iOp = OP_MTHI; iOperandA = 32'h55;
      @(posedge clk);
      #1;
      iStart = 1'b0; iOp = OP_NONE;
      finish_op("mthi_busy", W + 1 - 3);

      move_to("mthi_idle", OP_MTHI, 32'h55);
      move_to("mtlo_idle", OP_MTLO, 32'hA5A5_0F0F);

      // Asynchronous reset in the middle of a divide.
      start_op(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset/busy", {31'h0, oBusy}, 32'h0);
      check("midreset/hi", oHI, 32'h0);
      check("midreset/lo", oLO, 32'h0);
      check("midreset/done", {31'h0, oDone}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      exp_hi = 32'h0; exp_lo = 32'h0;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (oDone) dn++;
      end
      check("midreset/no_done", dn, 0);
      check("midreset/hold_hi", oHI, 32'h0);
      run_op("after_reset_mult", OP_MULT, 32'hFFFF_FF00, 32'h0001_0001);

      // Random ops with occasional zero divisors and overflow operands.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = rb >> $urandom_range(16, 31);
            default: rb = rb;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
